// File: rtl/fetch_pf_pkg.sv
// Shared types and constants for the prefetching fetch unit (fetch_pf).
package fetch_pf_pkg;

    localparam int unsigned PF_AD_LEN     = 32;
    localparam int unsigned PF_INST_WIDTH = 32;
    localparam int unsigned PC_INCR       = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DRAIN,
        ST_HALT
    } fetch_pf_state_t;

    // Entry fields are sized for the default bus/PC widths; narrower builds zero-extend.
    typedef struct packed {
        logic                     fault;
        logic [PF_AD_LEN-1:0]     pc;
        logic [PF_INST_WIDTH-1:0] inst;
    } fetch_pf_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction queue for fetch_pf: push, pop, flush, count, full/empty.
module fetch_fifo
    import fetch_pf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fetch_pf_entry_t        data_i,
    output fetch_pf_entry_t        head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_pf_entry_t mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == CW'(DEPTH));
    assign count_o = count;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Head reads as zero when empty so the consumer-facing outputs are clean after reset/flush.
    assign head_o  = empty_o ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!reset_ni || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/fetch_pf.sv
// Prefetching instruction fetch unit: request/grant bus port feeding a PC-tagged queue.
// Define FETCH_PF_FAULT_EN to record bus errors per entry and halt fetching on them.
module fetch_pf
    import fetch_pf_pkg::*;
#(
    parameter int unsigned       AD_LEN     = PF_AD_LEN,
    parameter int unsigned       INST_WIDTH = PF_INST_WIDTH,
    parameter int unsigned       DEPTH      = 4,
    parameter logic [AD_LEN-1:0] RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    output logic                  bus_req_o,
    output logic [AD_LEN-1:0]     bus_ad_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    input  logic [INST_WIDTH-1:0] bus_data_i,
    input  logic                  bus_err_i,
    input  logic                  redirect_i,
    input  logic [AD_LEN-1:0]     redirect_pc_i,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [AD_LEN-1:0]     inst_pc_o,
    output logic                  inst_fault_o,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_pf_state_t   state_q, state_d;
    logic [AD_LEN-1:0] pc_q, pc_d;
    logic              push, pop, flush, fault_in;
    logic              full, empty;
    logic [CW-1:0]     count;
    fetch_pf_entry_t   wr_entry, head;

`ifdef FETCH_PF_FAULT_EN
    assign fault_in = bus_err_i;
`else
    logic unused_bus_err;
    assign unused_bus_err = bus_err_i;
    assign fault_in       = 1'b0;
`endif

    assign pop            = !empty && inst_ready_i;
    assign wr_entry.fault = fault_in;
    assign wr_entry.pc    = PF_AD_LEN'(pc_q);
    assign wr_entry.inst  = PF_INST_WIDTH'(bus_data_i);

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  (wr_entry),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (redirect_i) begin
            flush = 1'b1;
            pc_d  = {redirect_pc_i[AD_LEN-1:2], 2'b00};
            // DRAIN leaves as soon as the outstanding response lands, even under a redirect,
            // so a redirect coinciding with that response cannot wait on a response that never comes.
            unique case (state_q)
                ST_REQ:   state_d = bus_gnt_i    ? ST_DRAIN : ST_IDLE;
                ST_WAIT:  state_d = bus_rvalid_i ? ST_IDLE  : ST_DRAIN;
                ST_DRAIN: state_d = bus_rvalid_i ? ST_IDLE  : ST_DRAIN;
                default:  state_d = ST_IDLE;
            endcase
        end else begin
            unique case (state_q)
                ST_IDLE: if (!full) state_d = ST_REQ;
                ST_REQ:  if (bus_gnt_i) state_d = ST_WAIT;
                ST_WAIT: begin
                    if (bus_rvalid_i) begin
                        push = 1'b1;
                        pc_d = pc_q + AD_LEN'(PC_INCR);
                        if (fault_in)
                            state_d = ST_HALT;
                        else if (count == CW'(DEPTH - 1) && !pop)
                            state_d = ST_IDLE;
                        else
                            state_d = ST_REQ;
                    end
                end
                ST_DRAIN: if (bus_rvalid_i) state_d = ST_IDLE;
                ST_HALT:  state_d = ST_HALT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    assign bus_req_o    = (state_q == ST_REQ);
    assign bus_ad_o     = pc_q;
    assign inst_valid_o = !empty;
    assign inst_o       = INST_WIDTH'(head.inst);
    assign inst_pc_o    = AD_LEN'(head.pc);
    assign inst_fault_o = head.fault;

endmodule
